// File: rtl/i2s_pkg.sv
// Shared types and default constants for the I2S frame feeder.
package i2s_pkg;

  localparam int unsigned I2S_DATA_BIT        = 16;
  localparam int unsigned I2S_SCLK_COUNT      = 64;
  localparam int unsigned I2S_MCLK_SCLK_RATIO = 4;
  localparam int unsigned I2S_FIFO_DEPTH      = 4;

  typedef struct packed {
    logic [I2S_DATA_BIT-1:0] l;
    logic [I2S_DATA_BIT-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo samples; push is ignored when full, pop is ignored when empty.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned Depth    = I2S_FIFO_DEPTH,
  parameter type         sample_t = stereo_sample_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  sample_t                data_i,
  input  logic                   pop_i,
  output sample_t                data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  sample_t           mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/i2s_frame_feeder.sv
// Buffers stereo samples and generates BCLK/LRCLK, frame load and bit shift strobes from MCLK.
// Define I2S_FEED_HOLD_LAST_EN to hold the previous sample on underrun instead of sending zero.
module i2s_frame_feeder
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_BIT        = I2S_DATA_BIT,
  parameter int unsigned SCLK_COUNT      = I2S_SCLK_COUNT,
  parameter int unsigned MCLK_SCLK_RATIO = I2S_MCLK_SCLK_RATIO,
  parameter int unsigned FIFO_DEPTH      = I2S_FIFO_DEPTH
) (
  input  logic                        i_clk_12_288,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic                        i_sample_valid,
  output logic                        o_sample_ready,
  input  logic [DATA_BIT-1:0]         i_sample_l,
  input  logic [DATA_BIT-1:0]         i_sample_r,
  output logic [DATA_BIT-1:0]         o_audio_l,
  output logic [DATA_BIT-1:0]         o_audio_r,
  output logic                        o_data_valid,
  output logic                        o_sclk_tick,
  output logic                        o_bclk,
  output logic                        o_lrclk,
  output logic                        o_underrun,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int unsigned DivW = $clog2(MCLK_SCLK_RATIO);
  localparam int unsigned BitW = $clog2(SCLK_COUNT);

  localparam logic [DivW-1:0] DivLast  = DivW'(MCLK_SCLK_RATIO - 1);
  localparam logic [DivW-1:0] DivPop   = DivW'(MCLK_SCLK_RATIO - 2);
  localparam logic [DivW-1:0] DivHalf  = DivW'(MCLK_SCLK_RATIO / 2);
  localparam logic [BitW-1:0] BitFirst = BitW'(SCLK_COUNT - 1);
  localparam logic [BitW-1:0] BitHalf  = BitW'(SCLK_COUNT / 2);

  typedef struct packed {
    logic [DATA_BIT-1:0] l;
    logic [DATA_BIT-1:0] r;
  } frame_sample_t;

  logic [DivW-1:0] div_q, div_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic            prime_q, prime_d;
  logic            boundary;
  logic            pop;
  logic            fifo_full, fifo_empty;
  frame_sample_t   fifo_head, push_data;
  frame_sample_t   audio_q, audio_d;
  logic            underrun_q, underrun_d;

  // prime_q marks the first bit period after idle as a frame boundary, so the first
  // load follows enable within one BCLK instead of a whole frame later.
  assign boundary = (bit_q == '0) || prime_q;
  assign pop      = i_enable && (div_q == DivPop) && boundary;

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    prime_d = prime_q;
    if (!i_enable) begin
      div_d   = '0;
      bit_d   = BitFirst;
      prime_d = 1'b1;
    end else if (div_q == DivLast) begin
      div_d = '0;
      if (boundary) begin
        bit_d   = BitFirst;
        prime_d = 1'b0;
      end else begin
        bit_d = bit_q - 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_comb begin
    audio_d    = audio_q;
    underrun_d = 1'b0;
    if (pop) begin
      if (!fifo_empty) begin
        audio_d = fifo_head;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_FEED_HOLD_LAST_EN
        audio_d = audio_q;
`else
        audio_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q      <= '0;
      bit_q      <= BitFirst;
      prime_q    <= 1'b1;
      audio_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bit_q      <= bit_d;
      prime_q    <= prime_d;
      audio_q    <= audio_d;
      underrun_q <= underrun_d;
    end
  end

  assign push_data = '{l: i_sample_l, r: i_sample_r};

  i2s_sample_fifo #(
    .Depth    (FIFO_DEPTH),
    .sample_t (frame_sample_t)
  ) u_fifo (
    .clk_i   (i_clk_12_288),
    .rst_ni  (i_reset_n),
    .push_i  (i_sample_valid),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_fifo_level)
  );

  // Strobes and pins decode straight from registers; idle (div 0) can never strobe.
  assign o_data_valid   = (div_q == DivLast) && boundary;
  assign o_sclk_tick    = (div_q == DivLast) && !boundary;
  assign o_bclk         = (div_q >= DivHalf);
  assign o_lrclk        = (bit_q != '0) && (bit_q <= BitHalf);
  assign o_underrun     = underrun_q;
  assign o_sample_ready = !fifo_full;
  assign o_audio_l      = audio_q.l;
  assign o_audio_r      = audio_q.r;

endmodule

// File: tb/tb_i2s_frame_feeder.sv
// Scoreboard bench for i2s_frame_feeder with default parameters (frame = 256 MCLK).
module tb_i2s_frame_feeder;

`ifdef I2S_FEED_HOLD_LAST_EN
  localparam bit HoldLast = 1'b1;
`else
  localparam bit HoldLast = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_l, s_r;
  logic [15:0] a_l, a_r;
  logic        dv, tick, bclk, lrclk, underrun;
  logic [2:0]  level;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;
  int   en_cnt = 0;
  int   tick_cnt = 0;
  bit   sb_on = 1'b0;
  smp_t exp_q[$];
  int   dv_idx[$];
  smp_t last_s = '0;
  smp_t exp_s;
  logic exp_un;

  i2s_frame_feeder dut (
    .i_clk_12_288   (clk),
    .i_reset_n      (rst_n),
    .i_enable       (en),
    .i_sample_valid (s_valid),
    .o_sample_ready (s_ready),
    .i_sample_l     (s_l),
    .i_sample_r     (s_r),
    .o_audio_l      (a_l),
    .o_audio_r      (a_r),
    .o_data_valid   (dv),
    .o_sclk_tick    (tick),
    .o_bclk         (bclk),
    .o_lrclk        (lrclk),
    .o_underrun     (underrun),
    .o_fifo_level   (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard: every frame load pops the expected sample, or expects an underrun.
  always @(negedge clk) begin
    if (sb_on) begin
      if (tick === 1'b1) tick_cnt = tick_cnt + 1;
      if (dv === 1'b1) begin
        dv_idx.push_back(cyc_cnt - en_cnt);
        if (exp_q.size() != 0) begin
          exp_s  = exp_q.pop_front();
          exp_un = 1'b0;
          last_s = exp_s;
        end else begin
          exp_s  = HoldLast ? last_s : '0;
          exp_un = 1'b1;
        end
        n_cmp = n_cmp + 1;
        if ({a_l, a_r, underrun} !== {exp_s.l, exp_s.r, exp_un}) begin
          n_bad = n_bad + 1;
          $display("FAIL frame_load: got L=%h R=%h un=%b, required L=%h R=%h un=%b",
                   a_l, a_r, underrun, exp_s.l, exp_s.r, exp_un);
        end
      end else if (underrun !== 1'b0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL underrun_stray: got %b outside a load cycle, required 0", underrun);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [15:0] l, input logic [15:0] r, input bit accept);
    s_valid = 1'b1;
    s_l     = l;
    s_r     = r;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== accept) begin
      n_bad++;
      $display("FAIL push_ready: got %b, required %b", s_ready, accept);
    end
    if (accept) exp_q.push_back('{l: l, r: r});
    next_cycle();
    s_valid = 1'b0;
  endtask

  task automatic start_enable();
    dv_idx.delete();
    tick_cnt = 0;
    en_cnt   = cyc_cnt;
    en       = 1'b1;
  endtask

  task automatic test_reset();
    int act;
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_l = '0; s_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dv, tick, bclk, lrclk, underrun} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b, required 00000", {dv, tick, bclk, lrclk, underrun});
    end
    n_cmp++;
    if ({a_l, a_r} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_audio: got %h, required 0", {a_l, a_r});
    end
    n_cmp++;
    if ({s_ready, level} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ready_level: got ready=%b level=%0d, required 1/0", s_ready, level);
    end
    next_cycle();
    rst_n = 1'b1;
    sb_on = 1'b1;
    act   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({dv, tick, bclk, lrclk, underrun} !== 5'b0 || s_ready !== 1'b1 || level !== 3'd0)
        act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL idle_quiet: got %0d active cycles, required 0", act);
    end
    next_cycle();
  endtask

  task automatic test_frames();
    int idx, bad_b, bad_lr, bad_dv, bad_tk;
    push_sample(16'h1111, 16'h2222, 1'b1);
    push_sample(16'h3333, 16'h4444, 1'b1);
    n_cmp++;
    if (level !== 3'd2) begin
      n_bad++;
      $display("FAIL frames_level: got %0d, required 2", level);
    end
    bad_b = 0; bad_lr = 0; bad_dv = 0; bad_tk = 0;
    start_enable();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      idx = cyc_cnt - en_cnt;
      if (bclk !== ((idx % 4) >= 2)) bad_b++;
      if (lrclk !== ((idx % 256) >= 128)) bad_lr++;
      if (dv !== ((idx % 256) == 3)) bad_dv++;
      if (tick !== ((idx % 4) == 3 && (idx % 256) != 3)) bad_tk++;
    end
    next_cycle();
    en = 1'b0;
    n_cmp++;
    if (bad_b != 0) begin n_bad++; $display("FAIL bclk_timing: got %0d bad cycles, required 0", bad_b); end
    n_cmp++;
    if (bad_lr != 0) begin n_bad++; $display("FAIL lrclk_timing: got %0d bad cycles, required 0", bad_lr); end
    n_cmp++;
    if (bad_dv != 0) begin n_bad++; $display("FAIL load_timing: got %0d bad cycles, required 0", bad_dv); end
    n_cmp++;
    if (bad_tk != 0) begin n_bad++; $display("FAIL tick_timing: got %0d bad cycles, required 0", bad_tk); end
    n_cmp++;
    if (dv_idx.size() != 2 || dv_idx[0] != 3 || dv_idx[1] != 259) begin
      n_bad++;
      $display("FAIL load_cycles: got %0d loads (first %0d), required loads at 3 and 259",
               dv_idx.size(), (dv_idx.size() != 0) ? dv_idx[0] : -1);
    end
    n_cmp++;
    if (tick_cnt != 63) begin n_bad++; $display("FAIL tick_count: got %0d, required 63", tick_cnt); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL frames_drained: got %0d left, required 0", exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_full();
    logic rdy2, rdy3;
    logic [2:0] lvl3;
    push_sample(16'hA001, 16'hB001, 1'b1);
    push_sample(16'hA002, 16'hB002, 1'b1);
    push_sample(16'hA003, 16'hB003, 1'b1);
    push_sample(16'hA004, 16'hB004, 1'b1);
    n_cmp++;
    if ({s_ready, level} !== {1'b0, 3'd4}) begin
      n_bad++;
      $display("FAIL full_state: got ready=%b level=%0d, required 0/4", s_ready, level);
    end
    push_sample(16'hDEAD, 16'hBEEF, 1'b0);
    n_cmp++;
    if (level !== 3'd4) begin
      n_bad++;
      $display("FAIL full_reject: got level %0d, required 4", level);
    end
    rdy2 = 1'bx; rdy3 = 1'bx; lvl3 = 'x;
    start_enable();
    for (int i = 0; i < 772; i++) begin
      @(negedge clk);
      if (cyc_cnt - en_cnt == 2) rdy2 = s_ready;
      if (cyc_cnt - en_cnt == 3) begin rdy3 = s_ready; lvl3 = level; end
    end
    next_cycle();
    en = 1'b0;
    n_cmp++;
    if ({rdy2, rdy3, lvl3} !== {1'b0, 1'b1, 3'd3}) begin
      n_bad++;
      $display("FAIL ready_after_pop: got ready@2=%b ready@3=%b level@3=%0d, required 0/1/3",
               rdy2, rdy3, lvl3);
    end
    n_cmp++;
    if (dv_idx.size() != 4 || dv_idx[3] != 771) begin
      n_bad++;
      $display("FAIL full_loads: got %0d loads, required 4 ending at 771", dv_idx.size());
    end
    n_cmp++;
    if (exp_q.size() != 0 || level !== 3'd0) begin
      n_bad++;
      $display("FAIL full_drained: got %0d left level %0d, required 0/0", exp_q.size(), level);
    end
    next_cycle();
  endtask

  task automatic test_underrun();
    int un_cnt;
    un_cnt = 0;
    start_enable();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) un_cnt++;
    end
    next_cycle();
    en = 1'b0;
    n_cmp++;
    if (un_cnt != 2 || dv_idx.size() != 2) begin
      n_bad++;
      $display("FAIL underrun_count: got %0d pulses %0d loads, required 2/2", un_cnt, dv_idx.size());
    end
    next_cycle();
  endtask

  task automatic test_enable_gap();
    int act;
    push_sample(16'h5555, 16'h6666, 1'b1);
    push_sample(16'h7777, 16'h8888, 1'b1);
    start_enable();
    repeat (101) @(negedge clk);
    next_cycle();
    en  = 1'b0;
    act = 0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({dv, tick, bclk, lrclk, underrun} !== 5'b0) act++;
    end
    n_cmp++;
    if (act != 0 || dv_idx.size() != 1) begin
      n_bad++;
      $display("FAIL gap_idle: got %0d active cycles %0d loads, required 0/1", act, dv_idx.size());
    end
    n_cmp++;
    if (level !== 3'd1) begin
      n_bad++;
      $display("FAIL gap_fifo_kept: got level %0d, required 1", level);
    end
    next_cycle();
    start_enable();
    repeat (8) @(negedge clk);
    next_cycle();
    en = 1'b0;
    n_cmp++;
    if (dv_idx.size() != 1 || dv_idx[0] != 3) begin
      n_bad++;
      $display("FAIL resume_load: got %0d loads (first %0d), required one at 3",
               dv_idx.size(), (dv_idx.size() != 0) ? dv_idx[0] : -1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL resume_drained: got %0d left, required 0", exp_q.size()); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_frames();
    test_full();
    test_underrun();
    test_enable_gap();
    repeat (4) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
